// File: rtl/rx_ordered_set_detect_pkg.sv
// SGMII receive code-group definitions and pipeline types shared by the
// ordered-set detector and its triple classifier.
package rx_ordered_set_detect_pkg;

  localparam logic [7:0] K28_1 = 8'h3C;
  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_7 = 8'hFC;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K23_7 = 8'hF7;
  localparam logic [7:0] K30_7 = 8'hFE;
  localparam logic [7:0] D21_5 = 8'hB5;
  localparam logic [7:0] D2_2  = 8'h42;
  localparam logic [7:0] D5_6  = 8'hC5;
  localparam logic [7:0] D16_2 = 8'h50;
  localparam logic [7:0] D0_0  = 8'h00;

  // Bit positions inside the check_end and ordered-set flag vectors.
  localparam int CE_KDK = 0, CE_KD215D00 = 1, CE_KD22D00 = 2, CE_TRK = 3;
  localparam int CE_TRR = 4, CE_RRR = 5, CE_RRK = 6, CE_RRS = 7;
  localparam int OS_C1 = 0, OS_C2 = 1, OS_I1 = 2, OS_I2 = 3;
  localparam int OS_S = 4, OS_T = 5, OS_R = 6, OS_V = 7;

  typedef struct packed {
    logic [7:0] data;
    logic       ctrl;
    logic       invalid;
  } codeGroup_t;

  localparam codeGroup_t CG_RESET = '{data: 8'h00, ctrl: 1'b0, invalid: 1'b1};

  function automatic logic isK(input codeGroup_t cg, input logic [7:0] code);
    return cg.ctrl && !cg.invalid && (cg.data == code);
  endfunction

  function automatic logic isD(input codeGroup_t cg, input logic [7:0] code);
    return !cg.ctrl && !cg.invalid && (cg.data == code);
  endfunction

  function automatic logic isAnyD(input codeGroup_t cg);
    return !cg.ctrl && !cg.invalid;
  endfunction

  function automatic logic isComma(input codeGroup_t cg);
    return isK(cg, K28_1) || isK(cg, K28_5) || isK(cg, K28_7);
  endfunction

endpackage

// File: rtl/rx_ordered_set_detect_if.sv
// Code-group stream into the detector and the delayed, classified stream out.
interface rx_ordered_set_detect_if;
  // No back-pressure: one code group is transferred every clock, qualified
  // only by i_SyncOk; outputs are likewise valid on every clock.
  logic [7:0] i8_RxCodeGroup;
  logic       i_RxCodeCtrl;
  logic       i_RxCodeInvalid;
  logic       i_SyncOk;

  logic [7:0] o8_RxCodeGroupOut;
  logic       o_RxCodeCtrlOut, o_RxCodeInvalidOut, o_RxEven, o_IsComma;
  logic       o_OrderedSetValid;
  logic       o_IsC1Set, o_IsC2Set, o_IsI1Set, o_IsI2Set;
  logic       o_IsSSet, o_IsTSet, o_IsRSet, o_IsVSet;
  logic       o_CheckEndKDK, o_CheckEndKD21_5D0_0, o_CheckEndKD2_2D0_0;
  logic       o_CheckEndTRK, o_CheckEndTRR, o_CheckEndRRR;
  logic       o_CheckEndRRK, o_CheckEndRRS;

  modport master (
    output i8_RxCodeGroup, i_RxCodeCtrl, i_RxCodeInvalid, i_SyncOk,
    input  o8_RxCodeGroupOut, o_RxCodeCtrlOut, o_RxCodeInvalidOut, o_RxEven,
           o_IsComma, o_OrderedSetValid, o_IsC1Set, o_IsC2Set, o_IsI1Set,
           o_IsI2Set, o_IsSSet, o_IsTSet, o_IsRSet, o_IsVSet, o_CheckEndKDK,
           o_CheckEndKD21_5D0_0, o_CheckEndKD2_2D0_0, o_CheckEndTRK,
           o_CheckEndTRR, o_CheckEndRRR, o_CheckEndRRK, o_CheckEndRRS
  );

  modport slave (
    input  i8_RxCodeGroup, i_RxCodeCtrl, i_RxCodeInvalid, i_SyncOk,
    output o8_RxCodeGroupOut, o_RxCodeCtrlOut, o_RxCodeInvalidOut, o_RxEven,
           o_IsComma, o_OrderedSetValid, o_IsC1Set, o_IsC2Set, o_IsI1Set,
           o_IsI2Set, o_IsSSet, o_IsTSet, o_IsRSet, o_IsVSet, o_CheckEndKDK,
           o_CheckEndKD21_5D0_0, o_CheckEndKD2_2D0_0, o_CheckEndTRK,
           o_CheckEndTRR, o_CheckEndRRR, o_CheckEndRRK, o_CheckEndRRS
  );
endinterface

// File: rtl/rx_triple_match.sv
// Combinational classifier over three consecutive code groups (a oldest):
// ordered-set type of a and the clause-36 check_end triple matches.
module rx_triple_match
  import rx_ordered_set_detect_pkg::*;
(
  input  codeGroup_t a,
  input  codeGroup_t b,
  input  codeGroup_t c,
  output logic [7:0] checkEnd,
  output logic [7:0] isSet
);

  logic aT, aR, bR, cR, cS, aK, cK;

  always_comb begin
    aK = isK(a, K28_5);
    cK = isK(c, K28_5);
    aT = isK(a, K29_7);
    aR = isK(a, K23_7);
    bR = isK(b, K23_7);
    cR = isK(c, K23_7);
    cS = isK(c, K27_7);

    checkEnd              = '0;
    checkEnd[CE_KDK]      = aK && isAnyD(b) && cK;
    checkEnd[CE_KD215D00] = aK && isD(b, D21_5) && isD(c, D0_0);
    checkEnd[CE_KD22D00]  = aK && isD(b, D2_2) && isD(c, D0_0);
    checkEnd[CE_TRK]      = aT && bR && cK;
    checkEnd[CE_TRR]      = aT && bR && cR;
    checkEnd[CE_RRR]      = aR && bR && cR;
    checkEnd[CE_RRK]      = aR && bR && cK;
    checkEnd[CE_RRS]      = aR && bR && cS;

    isSet        = '0;
    isSet[OS_C1] = aK && isD(b, D21_5);
    isSet[OS_C2] = aK && isD(b, D2_2);
    isSet[OS_I1] = aK && isD(b, D5_6);
    isSet[OS_I2] = aK && isD(b, D16_2);
    isSet[OS_S]  = isK(a, K27_7);
    isSet[OS_T]  = aT;
    isSet[OS_R]  = aR;
    // A code group that failed decode is reported as an error-propagation set.
    isSet[OS_V]  = isK(a, K30_7) || a.invalid;
  end

endmodule

// File: rtl/rx_ordered_set_detect.sv
// Three-deep lookahead pipeline ahead of the SGMII PCS receive FSM.
// Optional invalid-code counter built when RX_CODE_ERR_CNT_EN is defined.
module rx_ordered_set_detect
  import rx_ordered_set_detect_pkg::*;
#(
  parameter int PIPE_DEPTH = 3
) (
  input  logic                   i_Clk,
  input  logic                   i_ARst_L,
  rx_ordered_set_detect_if.slave rxIf,
  input  logic                   i_ClrErrCnt,
  output logic [15:0]            o16_CodeErrCnt
);

  if (PIPE_DEPTH != 3) begin : gBadPipeDepth
    $error("rx_ordered_set_detect: PIPE_DEPTH must be 3");
  end

  codeGroup_t inGroup, stageC, stageB;
  logic [7:0] outData;
  logic       outCtrl, invalidOutQ, evenQ, commaQ, osValidQ;
  logic [7:0] checkEndNext, isSetNext, checkEndQ, isSetQ;
  logic [1:0] fillCnt, fillNext;
  logic       flagsEn;

  assign inGroup = '{data: rxIf.i8_RxCodeGroup, ctrl: rxIf.i_RxCodeCtrl,
                     invalid: rxIf.i_RxCodeInvalid};

  // Flags are trusted only when B, C and the incoming group all arrived in sync.
  always_comb begin
    fillNext = 2'd0;
    if (rxIf.i_SyncOk) fillNext = (fillCnt == 2'd3) ? 2'd3 : fillCnt + 2'd1;
  end
  assign flagsEn = (fillNext == 2'd3);

  rx_triple_match u_triple_match (
    .a        (stageB),
    .b        (stageC),
    .c        (inGroup),
    .checkEnd (checkEndNext),
    .isSet    (isSetNext)
  );

  always_ff @(posedge i_Clk or negedge i_ARst_L) begin
    if (!i_ARst_L) begin
      stageC      <= CG_RESET;
      stageB      <= CG_RESET;
      outData     <= CG_RESET.data;
      outCtrl     <= CG_RESET.ctrl;
      invalidOutQ <= CG_RESET.invalid;
      fillCnt     <= 2'd0;
      evenQ       <= 1'b0;
      commaQ      <= 1'b0;
      osValidQ    <= 1'b0;
      checkEndQ   <= '0;
      isSetQ      <= '0;
    end else begin
      stageC      <= inGroup;
      stageB      <= stageC;
      outData     <= stageB.data;
      outCtrl     <= stageB.ctrl;
      invalidOutQ <= stageB.invalid || !flagsEn;
      fillCnt     <= fillNext;
      evenQ       <= isComma(stageB) ? 1'b1 : !evenQ;
      commaQ      <= isComma(stageB);
      osValidQ    <= flagsEn && (|isSetNext);
      checkEndQ   <= flagsEn ? checkEndNext : 8'h00;
      isSetQ      <= flagsEn ? isSetNext : 8'h00;
    end
  end

  assign rxIf.o8_RxCodeGroupOut    = outData;
  assign rxIf.o_RxCodeCtrlOut      = outCtrl;
  assign rxIf.o_RxCodeInvalidOut   = invalidOutQ;
  assign rxIf.o_RxEven             = evenQ;
  assign rxIf.o_IsComma            = commaQ;
  assign rxIf.o_OrderedSetValid    = osValidQ;
  assign rxIf.o_IsC1Set            = isSetQ[OS_C1];
  assign rxIf.o_IsC2Set            = isSetQ[OS_C2];
  assign rxIf.o_IsI1Set            = isSetQ[OS_I1];
  assign rxIf.o_IsI2Set            = isSetQ[OS_I2];
  assign rxIf.o_IsSSet             = isSetQ[OS_S];
  assign rxIf.o_IsTSet             = isSetQ[OS_T];
  assign rxIf.o_IsRSet             = isSetQ[OS_R];
  assign rxIf.o_IsVSet             = isSetQ[OS_V];
  assign rxIf.o_CheckEndKDK        = checkEndQ[CE_KDK];
  assign rxIf.o_CheckEndKD21_5D0_0 = checkEndQ[CE_KD215D00];
  assign rxIf.o_CheckEndKD2_2D0_0  = checkEndQ[CE_KD22D00];
  assign rxIf.o_CheckEndTRK        = checkEndQ[CE_TRK];
  assign rxIf.o_CheckEndTRR        = checkEndQ[CE_TRR];
  assign rxIf.o_CheckEndRRR        = checkEndQ[CE_RRR];
  assign rxIf.o_CheckEndRRK        = checkEndQ[CE_RRK];
  assign rxIf.o_CheckEndRRS        = checkEndQ[CE_RRS];

`ifdef RX_CODE_ERR_CNT_EN
  logic [15:0] errCnt;

  always_ff @(posedge i_Clk or negedge i_ARst_L) begin
    if (!i_ARst_L) begin
      errCnt <= 16'h0000;
    end else if (i_ClrErrCnt) begin
      errCnt <= 16'h0000;
    end else if (rxIf.i_RxCodeInvalid && rxIf.i_SyncOk && (errCnt != 16'hFFFF)) begin
      errCnt <= errCnt + 16'h0001;
    end
  end

  assign o16_CodeErrCnt = errCnt;
`else
  logic unusedClrErrCnt;
  assign unusedClrErrCnt = i_ClrErrCnt;
  assign o16_CodeErrCnt  = 16'h0000;
`endif

endmodule

// File: tb/tb_rx_ordered_set_detect.sv
// Directed bench for rx_ordered_set_detect: idle stream, ordered sets,
// check_end triples, sync loss, async reset and the optional error counter.
module tb_rx_ordered_set_detect;

  localparam logic [7:0] OS_C1 = 8'h01, OS_C2 = 8'h02, OS_I1 = 8'h04, OS_I2 = 8'h08;
  localparam logic [7:0] OS_S = 8'h10, OS_T = 8'h20, OS_R = 8'h40, OS_V = 8'h80;
  localparam logic [7:0] CE_KDK = 8'h01, CE_KD215 = 8'h02, CE_KD22 = 8'h04, CE_TRK = 8'h08;
  localparam logic [7:0] CE_TRR = 8'h10, CE_RRR = 8'h20, CE_RRK = 8'h40, CE_RRS = 8'h80;
`ifdef RX_CODE_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic        i_Clk = 1'b0;
  logic        i_ARst_L;
  logic        clrErrCnt;
  logic [15:0] codeErrCnt;

  always #4 i_Clk = ~i_Clk;

  rx_ordered_set_detect_if rxIf ();

  rx_ordered_set_detect dut (
    .i_Clk          (i_Clk),
    .i_ARst_L       (i_ARst_L),
    .rxIf           (rxIf),
    .i_ClrErrCnt    (clrErrCnt),
    .o16_CodeErrCnt (codeErrCnt)
  );

  // ---------------- scoreboard ----------------
  int         vectors     = 0;
  int         miscompares = 0;
  logic [8:0] exp_q[$];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] osObs();
    return {rxIf.o_IsVSet, rxIf.o_IsRSet, rxIf.o_IsTSet, rxIf.o_IsSSet,
            rxIf.o_IsI2Set, rxIf.o_IsI1Set, rxIf.o_IsC2Set, rxIf.o_IsC1Set};
  endfunction

  function automatic logic [7:0] ceObs();
    return {rxIf.o_CheckEndRRS, rxIf.o_CheckEndRRK, rxIf.o_CheckEndRRR,
            rxIf.o_CheckEndTRR, rxIf.o_CheckEndTRK, rxIf.o_CheckEndKD2_2D0_0,
            rxIf.o_CheckEndKD21_5D0_0, rxIf.o_CheckEndKDK};
  endfunction

  task automatic chkFlags(input string tag, input logic [7:0] os, input logic [7:0] ce,
                          input logic inv);
    check({tag, "_os"}, {8'h00, osObs()}, {8'h00, os});
    check({tag, "_ce"}, {8'h00, ceObs()}, {8'h00, ce});
    check({tag, "_osvalid"}, {15'd0, rxIf.o_OrderedSetValid}, {15'd0, |os});
    check({tag, "_invout"}, {15'd0, rxIf.o_RxCodeInvalidOut}, {15'd0, inv});
  endtask

  // ---------------- drivers ----------------
  task automatic send(input logic [7:0] d, input logic k, input logic inv,
                      input logic sync, input logic clr);
    logic [8:0] e;
    rxIf.i8_RxCodeGroup  = d;
    rxIf.i_RxCodeCtrl    = k;
    rxIf.i_RxCodeInvalid = inv;
    rxIf.i_SyncOk        = sync;
    clrErrCnt            = clr;
    @(posedge i_Clk);
    #1;
    exp_q.push_back({k, d});
    if (exp_q.size() == 3) begin
      e = exp_q.pop_front();
      check("pipe_out", {7'd0, rxIf.o_RxCodeCtrlOut, rxIf.o8_RxCodeGroupOut}, {7'd0, e});
    end
  endtask

  task automatic kk(input logic [7:0] d);
    send(d, 1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic dd(input logic [7:0] d);
    send(d, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic chkReset(input string tag);
    check({tag, "_data"}, {8'h00, rxIf.o8_RxCodeGroupOut}, 16'h0000);
    check({tag, "_ctrl"}, {15'd0, rxIf.o_RxCodeCtrlOut}, 16'h0000);
    check({tag, "_even"}, {15'd0, rxIf.o_RxEven}, 16'h0000);
    check({tag, "_comma"}, {15'd0, rxIf.o_IsComma}, 16'h0000);
    check({tag, "_errcnt"}, codeErrCnt, 16'h0000);
    chkFlags(tag, 8'h00, 8'h00, 1'b1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    i_ARst_L             = 1'b0;
    rxIf.i8_RxCodeGroup  = 8'h00;
    rxIf.i_RxCodeCtrl    = 1'b0;
    rxIf.i_RxCodeInvalid = 1'b0;
    rxIf.i_SyncOk        = 1'b0;
    clrErrCnt            = 1'b0;
    #21;
    chkReset("reset");
    @(negedge i_Clk);
    i_ARst_L = 1'b1;

    // Idle stream /I2/: flags held off for 3 cycles, then I2 on every BC.
    kk(8'hBC); chkFlags("fill1", 8'h00, 8'h00, 1'b1);
    check("fill1_even", {15'd0, rxIf.o_RxEven}, 16'd1);
    dd(8'h50); chkFlags("fill2", 8'h00, 8'h00, 1'b1);
    check("fill2_even", {15'd0, rxIf.o_RxEven}, 16'd0);
    for (int i = 0; i < 3; i++) begin
      kk(8'hBC); chkFlags("idle_bc", OS_I2, CE_KDK, 1'b0);
      check("idle_bc_even", {15'd0, rxIf.o_RxEven}, 16'd1);
      check("idle_bc_comma", {15'd0, rxIf.o_IsComma}, 16'd1);
      dd(8'h50); chkFlags("idle_50", 8'h00, 8'h00, 1'b0);
      check("idle_50_even", {15'd0, rxIf.o_RxEven}, 16'd0);
    end

    // /C1/ followed by D0.0: output BC shows C1 and KD21_5D0_0, not KDK.
    kk(8'hBC); dd(8'hB5); dd(8'h00);
    chkFlags("c1", OS_C1, CE_KD215, 1'b0);
    check("c1_even", {15'd0, rxIf.o_RxEven}, 16'd1);

    // T R K, then R at the output on the following cycle.
    kk(8'hFD); chkFlags("after_c1", 8'h00, 8'h00, 1'b0);
    kk(8'hF7); kk(8'hBC);
    chkFlags("trk", OS_T, CE_TRK, 1'b0);
    kk(8'hF7); chkFlags("trk_r", OS_R, 8'h00, 1'b0);

    // R R S.
    kk(8'hF7); chkFlags("trk_k", 8'h00, 8'h00, 1'b0);
    kk(8'hFB); chkFlags("rrs", OS_R, CE_RRS, 1'b0);

    // R R(invalid) S: no triple, invalid group reported as /V/.
    kk(8'hF7); chkFlags("rrs_r2", OS_R, 8'h00, 1'b0);
    send(8'hF7, 1'b1, 1'b1, 1'b1, 1'b0); chkFlags("rrs_s", OS_S, 8'h00, 1'b0);
    kk(8'hFB); chkFlags("rxs_r", OS_R, 8'h00, 1'b0);
    check("errcnt_off", codeErrCnt, CNT_EN ? 16'd1 : 16'd0);
    dd(8'h50); chkFlags("rxs_inv", OS_V, 8'h00, 1'b1);
    kk(8'hFE); chkFlags("rxs_s", OS_S, 8'h00, 1'b0);
    dd(8'h50); dd(8'h50);
    chkFlags("v_k30_7", OS_V, 8'h00, 1'b0);

    // Single-cycle loss of sync blanks the next 3 output groups.
    kk(8'hBC); dd(8'h50);
    send(8'hBC, 1'b1, 1'b0, 1'b0, 1'b0); chkFlags("nosync0", 8'h00, 8'h00, 1'b1);
    dd(8'h50); chkFlags("nosync1", 8'h00, 8'h00, 1'b1);
    kk(8'hBC); chkFlags("nosync2", 8'h00, 8'h00, 1'b1);
    dd(8'h50); chkFlags("resync_50", 8'h00, 8'h00, 1'b0);
    kk(8'hBC); chkFlags("resync_bc", OS_I2, CE_KDK, 1'b0);

    // Asynchronous reset mid-stream.
    i_ARst_L = 1'b0;
    #1;
    chkReset("midreset");
    exp_q.delete();
    @(negedge i_Clk);
    i_ARst_L = 1'b1;
    kk(8'hBC); chkFlags("rst_fill1", 8'h00, 8'h00, 1'b1);
    dd(8'h50); chkFlags("rst_fill2", 8'h00, 8'h00, 1'b1);
    kk(8'hBC); chkFlags("rst_first", OS_I2, CE_KDK, 1'b0);

    // Error counter: clear, count, clear-wins, ignore when out of sync.
    send(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    check("cnt_clr", codeErrCnt, 16'd0);
    for (int i = 0; i < 5; i++) send(8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    check("cnt_five", codeErrCnt, CNT_EN ? 16'd5 : 16'd0);
    send(8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    check("cnt_clr_wins", codeErrCnt, 16'd0);
    send(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    check("cnt_nosync", codeErrCnt, 16'd0);
    send(8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    check("cnt_one", codeErrCnt, CNT_EN ? 16'd1 : 16'd0);

`ifdef RX_CODE_ERR_CNT_EN
    // Run the counter into saturation and make sure it holds.
    rxIf.i_RxCodeInvalid = 1'b1;
    rxIf.i_SyncOk        = 1'b1;
    clrErrCnt            = 1'b0;
    repeat (65533) @(posedge i_Clk);
    #1;
    check("cnt_near_sat", codeErrCnt, 16'hFFFE);
    repeat (4) @(posedge i_Clk);
    #1;
    check("cnt_sat", codeErrCnt, 16'hFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
